// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-latency constants and buffer sizing helpers for the FIFO adapters
package fifo_pkg;
  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;
  function automatic int occ_width(input int cap);
    return $clog2(cap + 1);
  endfunction
  function automatic int ptr_width(input int cap);
    return (cap > 1) ? $clog2(cap) : 1;
  endfunction
endpackage

// File: rtl/stream_prefetch_buf.sv
// stream_prefetch_buf: small circular buffer with a register-driven head and synchronous flush
module stream_prefetch_buf
  import fifo_pkg::*;
#(
  parameter  int DWIDTH = 8,
  parameter  int CAP    = 2,
  localparam int OW     = occ_width(CAP),
  localparam int PW     = ptr_width(CAP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_pop,
  output logic [OW-1:0]     o_occ,
  output logic [DWIDTH-1:0] o_head
);
  logic [DWIDTH-1:0] r_mem [CAP];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [OW-1:0] r_occ;
  logic w_push, w_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(CAP - 1)) ? '0 : p + 1'b1;
  endfunction
  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && !i_flush && (r_occ != '0);
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop) r_rptr <= nxt(r_rptr);
      r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
    end
  end
  // storage is cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CAP; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end
  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rptr];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port into a valid/ready stream through a prefetch buffer
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int RD_LAT = 0,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              empty,
  output logic              rden,
  input  logic [DWIDTH-1:0] dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [1:0]        level,
  output logic [CWIDTH-1:0] pop_cnt
);
  localparam int CAP = RD_LAT + 2;
  localparam int OW  = occ_width(CAP);
  logic [OW-1:0] w_occ;
  logic [7:0] w_occ_x;
  logic w_infl, w_push, w_pop;
  logic [CWIDTH-1:0] r_pop_cnt;
  // reads in flight reserve a slot, so issue never depends on m_ready
  assign rden    = !rst && !empty && !flush && (int'(w_occ) + int'(w_infl) < CAP);
  assign m_valid = w_occ != '0;
  assign w_pop   = m_valid && m_ready && !flush;
  assign w_occ_x = 8'(w_occ);
  assign level   = (w_occ_x > 8'd3) ? 2'd3 : w_occ_x[1:0];
  assign pop_cnt = r_pop_cnt;
  generate
    if (RD_LAT == RD_LAT_COMB) begin : g_comb
      assign w_infl = 1'b0;
      assign w_push = rden;
    end else begin : g_reg
      logic r_issue_d;
      always_ff @(posedge clk) begin
        if (rst) r_issue_d <= 1'b0;
        else r_issue_d <= rden;
      end
      assign w_infl = r_issue_d;
      assign w_push = r_issue_d && !flush;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) r_pop_cnt <= '0;
    else if (w_pop) r_pop_cnt <= r_pop_cnt + 1'b1;
  end
  stream_prefetch_buf #(
    .DWIDTH(DWIDTH),
    .CAP   (CAP)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_flush(flush),
    .i_push (w_push),
    .i_data (dout),
    .i_pop  (w_pop),
    .o_occ  (w_occ),
    .o_head (m_data)
  );
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side adapter for the team's FIFOs. It drains a FIFO through its rden/dout/empty read port and presents the words as a valid/ready stream.
- It hides the FIFO read latency and the registered-empty behaviour using a small prefetch buffer.
- It runs entirely in the FIFO read clock domain and sits between the FIFO and any downstream consumer.

Parameters:
- DWIDTH, 8, data word width; must match the FIFO DWIDTH.
- RD_LAT, 0, FIFO read latency in cycles from rden to valid dout. Legal values are 0 (dout valid in the rden cycle) or 1 (dout valid the cycle after rden).
- CWIDTH, 16, width of the popped-word counter.

Ports:
- clk  input  1  block clock; same clock as the FIFO read side.
- rst  input  1  reset; synchronous and active-high.
- flush  input  1  synchronous flush of the prefetch buffer.
- empty  input  1  FIFO empty flag, registered by the FIFO.
- rden  output  1  FIFO read enable.
- dout  input  DWIDTH  FIFO read data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DWIDTH  stream data.
- level  output  2  current prefetch buffer occupancy.
- pop_cnt  output  CWIDTH  count of words accepted downstream.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high, on rst.
  - On rst = 1 at a clk edge: rden = 0, m_valid = 0, m_data = 0, level = 0, pop_cnt = 0. All in-flight reads are forgotten.
- Buffer structure:
  - Internal circular buffer with capacity CAP = RD_LAT + 2 entries.
  - Write and read pointers wrap modulo CAP.
  - occ is the occupancy, range 0..CAP.
  - infl is the number of issued reads whose data has not yet returned, range 0..RD_LAT.
- Issue rule:
  - rden = !empty && !flush && (occ + infl < CAP).
  - There is no combinational path from m_ready to rden.
  - rden is never asserted while empty = 1.
- Capture:
  - RD_LAT = 0: in a cycle with rden = 1, dout is written into the buffer at the clk edge.
  - RD_LAT = 1: the data is written one cycle after rden, tracked by a delayed issue flag.
- Output:
  - m_valid = (occ != 0).
  - m_data = buffer head, driven from registers only.
  - There is no combinational path from dout to m_data.
- Handshake:
  - A word is popped when m_valid && m_ready.
  - m_data must hold stable while m_valid && !m_ready.
  - Push and pop in the same cycle leave occ unchanged, and both pointers advance.
- Latency:
  - Empty falls at cycle t, so rden is asserted at t.
  - m_valid rises at t+1 when RD_LAT = 0, or at t+2 when RD_LAT = 1.
- Throughput: sustained 1 word per cycle when the FIFO stays non-empty and m_ready is held at 1, for both RD_LAT values.
- Full buffer: when occ + infl = CAP, rden is held low and m_valid stays high.
- flush = 1 at a clk edge:
  - occ becomes 0 and the pointers reset.
  - rden is low in the flush cycle.
  - Data still returning from reads issued before the flush (RD_LAT = 1) is discarded and not written.
  - pop_cnt is unaffected.
  - A pop is not counted in a flush cycle.
- pop_cnt increments on each pop and wraps modulo 2^CWIDTH.
- level = occ, saturating at 3 for the 2-bit output.
- Simultaneous rst and flush: rst wins.

Decomposition:
- Shared package fifo_pkg:
  - RD_LAT legal-value constants.
  - A function for the occupancy/pointer width of CAP.
- One sub-module: stream_prefetch_buf.
  - Parameterised circular buffer of depth CAP.
  - Provides push and pop, occ, a head register, and a flush input.
- The top level holds the issue/in-flight logic and pop_cnt.

Test Plan:
- Reset then idle: rst high for 3 cycles with empty = 1 -> rden = 0, m_valid = 0, m_data = 0, level = 0, pop_cnt = 0 throughout and after release.
- Streaming, RD_LAT = 0:
  - Stimulus: FIFO model holds 0x01..0x10 with m_ready = 1.
  - Response: rden rises in the same cycle empty falls, and m_valid follows 1 cycle later.
  - Response: 16 words appear in order on consecutive cycles, and pop_cnt = 16.
- Streaming, RD_LAT = 1:
  - Stimulus: same 16 words.
  - Response: m_valid rises 2 cycles after empty falls, then 1 word per cycle with no bubbles.
- Backpressure:
  - Stimulus: m_ready = 0 for 10 cycles with the FIFO non-empty.
  - Response: exactly CAP rden pulses occur, then rden stays 0 and level = CAP.
  - Response: m_data holds the first word.
  - Response: after m_ready = 1, all words arrive in order with none lost or duplicated.
- Flush mid-stream, RD_LAT = 1:
  - Stimulus: flush pulses while occ = 2 and infl = 1.
  - Response: the next cycle has m_valid = 0, and the returning in-flight word is dropped.
  - Response: streaming resumes with the next FIFO word, and pop_cnt is unchanged by the flush.
- Counter wrap and reset mid-operation:
  - Stimulus: CWIDTH = 4 with 17 pops, then rst asserted while occ = 2.
  - Response: pop_cnt reads 1 after the 17 pops.
  - Response: after rst, all outputs return to their reset values on the next edge.
